max7219_rx: RTL and testbench

- Responder-side model of the MAX7219 serial interface: receives 16-bit frames on DIN/CLK/LOAD and decodes them into the MAX7219 register set.
- Exposes decoded registers and a write strobe to the FPGA fabric.
- Used as an on-chip loopback target for the MAX7219 write path, and as a drop-in display emulator that drives the TM1638/LED display logic.
- Runs entirely in the i_Clk domain. The serial inputs are oversampled, not used as clocks.

---
 rtl/max7219_pkg.sv | 39 +++
 rtl/max7219_sync_edge.sv | 49 ++++
 rtl/max7219_rx.sv | 168 ++++++++++++++++
 tb/tb_max7219_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared constants and types for the MAX7219 responder model.
package max7219_pkg;

    // Register addresses as seen in frame bits [11:8]
    localparam logic [3:0] C_ADDR_NOOP         = 4'h0;
    localparam logic [3:0] C_ADDR_DIGIT0       = 4'h1;
    localparam logic [3:0] C_ADDR_DIGIT1       = 4'h2;
    localparam logic [3:0] C_ADDR_DIGIT2       = 4'h3;
    localparam logic [3:0] C_ADDR_DIGIT3       = 4'h4;
    localparam logic [3:0] C_ADDR_DIGIT4       = 4'h5;
    localparam logic [3:0] C_ADDR_DIGIT5       = 4'h6;
    localparam logic [3:0] C_ADDR_DIGIT6       = 4'h7;
    localparam logic [3:0] C_ADDR_DIGIT7       = 4'h8;
    localparam logic [3:0] C_ADDR_DECODE       = 4'h9;
    localparam logic [3:0] C_ADDR_INTENSITY    = 4'hA;
    localparam logic [3:0] C_ADDR_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] C_ADDR_SHUTDOWN     = 4'hC;
    localparam logic [3:0] C_ADDR_DISPLAY_TEST = 4'hF;

    // Nominal frame length and bit-counter saturation point
    localparam int         C_FRAME_BITS = 16;
    localparam logic [4:0] C_CNT_MAX    = 5'd31;

    // Receiver FSM states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } t_rx_state;

    // Register power-up values (device starts in shutdown)
    localparam logic [63:0] C_RST_DIGITS       = 64'h0;
    localparam logic [7:0]  C_RST_DECODE       = 8'h00;
    localparam logic [3:0]  C_RST_INTENSITY    = 4'h0;
    localparam logic [2:0]  C_RST_SCAN_LIMIT   = 3'h0;
    localparam logic        C_RST_SHUTDOWN_N   = 1'b0;
    localparam logic        C_RST_DISPLAY_TEST = 1'b0;

endpackage

// File: rtl/max7219_sync_edge.sv
// Multi-stage synchronizer for a raw asynchronous input, followed by a
// single history flop that turns level changes into one-cycle pulses.
module sync_edge #(
    parameter int P_STAGES = 2
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Async,
    output logic o_Rise,
    output logic o_Fall
);

    logic [P_STAGES-1:0] r_sync;
    logic                r_prev;
    logic                w_sync;

    // Synchronizer chain: stage 0 samples the raw pin, each later stage
    // samples its predecessor.
    genvar gi;
    generate
        for (gi = 0; gi < P_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage captures the asynchronous input
                always_ff @(posedge i_Clk or posedge i_Rst) begin
                    if (i_Rst) r_sync[gi] <= 1'b0;
                    else       r_sync[gi] <= i_Async;
                end
            end else begin : g_next
                // Later stages resolve metastability
                always_ff @(posedge i_Clk or posedge i_Rst) begin
                    if (i_Rst) r_sync[gi] <= 1'b0;
                    else       r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    assign w_sync = r_sync[P_STAGES-1];

    // History flop for edge detection
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) r_prev <= 1'b0;
        else       r_prev <= w_sync;
    end

    assign o_Rise = w_sync & ~r_prev;
    assign o_Fall = ~w_sync & r_prev;

endmodule

// File: rtl/max7219_rx.sv
// MAX7219 responder: oversamples DIN/CLK/LOAD, assembles 16-bit frames and
// decodes committed frames into the display register set.
module max7219_rx
    import max7219_pkg::*;
#(
    parameter int P_STRICT      = 1,
    parameter int P_SYNC_STAGES = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Sclk,
    input  logic        i_Din,
    input  logic        i_Load,
    output logic        o_Dout,
    output logic        o_Write_Valid,
    output logic [3:0]  o_Write_Addr,
    output logic [7:0]  o_Write_Data,
    output logic        o_Frame_Err,
    output logic [63:0] o_Digits,
    output logic [7:0]  o_Decode_Mode,
    output logic [3:0]  o_Intensity,
    output logic [2:0]  o_Scan_Limit,
    output logic        o_Shutdown_n,
    output logic        o_Display_Test
);

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_load_rise;
    logic w_load_fall;
    logic w_din_sync;

    logic [P_SYNC_STAGES-1:0] r_din_sync;

    t_rx_state   r_state;
    logic [15:0] r_sr;
    logic [4:0]  r_bit_cnt;
    logic        r_write_valid;
    logic [3:0]  r_write_addr;
    logic [7:0]  r_write_data;
    logic        r_frame_err;
    logic [63:0] r_digits;
    logic [7:0]  r_decode_mode;
    logic [3:0]  r_intensity;
    logic [2:0]  r_scan_limit;
    logic        r_shutdown_n;
    logic        r_display_test;

    logic        w_accept;
    logic [2:0]  w_digit_idx;

    sync_edge #(.P_STAGES(P_SYNC_STAGES)) u_sclk_sync (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Async (i_Sclk),
        .o_Rise  (w_sclk_rise),
        .o_Fall  (w_sclk_fall)
    );

    sync_edge #(.P_STAGES(P_SYNC_STAGES)) u_load_sync (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Async (i_Load),
        .o_Rise  (w_load_rise),
        .o_Fall  (w_load_fall)
    );

    // Data only needs the level; its depth matches the clock path so the
    // sampled bit lines up with the Sclk rise pulse.
    genvar gi;
    generate
        for (gi = 0; gi < P_SYNC_STAGES; gi++) begin : g_din
            if (gi == 0) begin : g_first
                // First data stage captures the raw pin
                always_ff @(posedge i_Clk or posedge i_Rst) begin
                    if (i_Rst) r_din_sync[gi] <= 1'b0;
                    else       r_din_sync[gi] <= i_Din;
                end
            end else begin : g_next
                // Remaining data stages
                always_ff @(posedge i_Clk or posedge i_Rst) begin
                    if (i_Rst) r_din_sync[gi] <= 1'b0;
                    else       r_din_sync[gi] <= r_din_sync[gi-1];
                end
            end
        end
    endgenerate

    assign w_din_sync = r_din_sync[P_SYNC_STAGES-1];

    // Cascade tolerance: relaxed mode keeps the last 16 bits of a long frame
    assign w_accept = (r_bit_cnt == 5'(C_FRAME_BITS)) ||
                      ((P_STRICT == 0) && (r_bit_cnt >= 5'(C_FRAME_BITS)));

    // Addresses 1..8 map to digits 0..7; 8 wraps to 7 in three bits
    assign w_digit_idx = r_sr[10:8] - 3'd1;

    // Frame FSM, shift register and register file with registered outputs
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state        <= S_IDLE;
            r_sr           <= 16'h0;
            r_bit_cnt      <= 5'd0;
            r_write_valid  <= 1'b0;
            r_write_addr   <= 4'h0;
            r_write_data   <= 8'h00;
            r_frame_err    <= 1'b0;
            r_digits       <= C_RST_DIGITS;
            r_decode_mode  <= C_RST_DECODE;
            r_intensity    <= C_RST_INTENSITY;
            r_scan_limit   <= C_RST_SCAN_LIMIT;
            r_shutdown_n   <= C_RST_SHUTDOWN_N;
            r_display_test <= C_RST_DISPLAY_TEST;
        end else begin
            r_write_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= 5'd0;
                    if (w_load_fall) r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    // A coincident Load rise still keeps this final bit
                    if (w_sclk_rise) begin
                        r_sr <= {r_sr[14:0], w_din_sync};
                        if (r_bit_cnt != C_CNT_MAX) r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                    if (w_load_rise) r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        r_write_valid <= 1'b1;
                        r_write_addr  <= r_sr[11:8];
                        r_write_data  <= r_sr[7:0];
                        case (r_sr[11:8])
                            C_ADDR_DIGIT0, C_ADDR_DIGIT1, C_ADDR_DIGIT2, C_ADDR_DIGIT3,
                            C_ADDR_DIGIT4, C_ADDR_DIGIT5, C_ADDR_DIGIT6, C_ADDR_DIGIT7:
                                r_digits[{w_digit_idx, 3'b000} +: 8] <= r_sr[7:0];
                            C_ADDR_DECODE:       r_decode_mode  <= r_sr[7:0];
                            C_ADDR_INTENSITY:    r_intensity    <= r_sr[3:0];
                            C_ADDR_SCAN_LIMIT:   r_scan_limit   <= r_sr[2:0];
                            C_ADDR_SHUTDOWN:     r_shutdown_n   <= r_sr[0];
                            C_ADDR_DISPLAY_TEST: r_display_test <= r_sr[0];
                            default: ;
                        endcase
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_Dout         = r_sr[15];
    assign o_Write_Valid  = r_write_valid;
    assign o_Write_Addr   = r_write_addr;
    assign o_Write_Data   = r_write_data;
    assign o_Frame_Err    = r_frame_err;
    assign o_Digits       = r_digits;
    assign o_Decode_Mode  = r_decode_mode;
    assign o_Intensity    = r_intensity;
    assign o_Scan_Limit   = r_scan_limit;
    assign o_Shutdown_n   = r_shutdown_n;
    assign o_Display_Test = r_display_test;

endmodule

// File: tb/tb_max7219_rx.sv
// Directed bench for max7219_rx: a strict and a cascade-tolerant instance
// share the same serial stimulus.
module tb_max7219_rx;

    logic clk = 1'b0;
    logic rst;
    logic sclk;
    logic din;
    logic load;

    logic        dout, wv, fe, shdn, dtest;
    logic [3:0]  waddr, inten;
    logic [7:0]  wdata, decm;
    logic [63:0] digits;
    logic [2:0]  scan;

    logic        dout_ns, wv_ns, fe_ns, shdn_ns, dtest_ns;
    logic [3:0]  waddr_ns, inten_ns;
    logic [7:0]  wdata_ns, decm_ns;
    logic [63:0] digits_ns;
    logic [2:0]  scan_ns;

    int n_tests = 0;
    int n_fail  = 0;
    int nv = 0, ne = 0, nv_ns = 0, ne_ns = 0;
    logic [15:0] dout_word;

    always #5 clk = ~clk;

    max7219_rx dut (
        .i_Clk(clk), .i_Rst(rst), .i_Sclk(sclk), .i_Din(din), .i_Load(load),
        .o_Dout(dout), .o_Write_Valid(wv), .o_Write_Addr(waddr), .o_Write_Data(wdata),
        .o_Frame_Err(fe), .o_Digits(digits), .o_Decode_Mode(decm), .o_Intensity(inten),
        .o_Scan_Limit(scan), .o_Shutdown_n(shdn), .o_Display_Test(dtest)
    );

    max7219_rx #(.P_STRICT(0)) dut_ns (
        .i_Clk(clk), .i_Rst(rst), .i_Sclk(sclk), .i_Din(din), .i_Load(load),
        .o_Dout(dout_ns), .o_Write_Valid(wv_ns), .o_Write_Addr(waddr_ns), .o_Write_Data(wdata_ns),
        .o_Frame_Err(fe_ns), .o_Digits(digits_ns), .o_Decode_Mode(decm_ns), .o_Intensity(inten_ns),
        .o_Scan_Limit(scan_ns), .o_Shutdown_n(shdn_ns), .o_Display_Test(dtest_ns)
    );

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (wv)    nv++;
        if (fe)    ne++;
        if (wv_ns) nv_ns++;
        if (fe_ns) ne_ns++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic frame_start();
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Shift bits [from, to) of an nb-bit frame, MSB first; dout is captured
    // just before each rise from bit 16 onward.
    task automatic shift_bits(input logic [31:0] f, input int nb, input int from, input int to);
        for (int i = from; i < to; i++) begin
            sclk = 1'b0;
            din  = f[nb-1-i];
            repeat (3) @(negedge clk);
            if (i >= 16) dout_word = {dout_word[14:0], dout_ns};
            sclk = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    // Raise Load and report how many i_Clk edges until a strobe or error
    task automatic frame_end(output int lat);
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        load = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (lat < 0 && (wv || fe)) lat = k;
        end
    endtask

    typedef struct {
        logic [31:0] frame;
        int          nbits;
        int          exp_valid;
        int          exp_err;
        logic [3:0]  exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lat;
        int v0, e0, v0n, e0n;

        vecs[0] = '{32'h0C01, 16, 1, 0, 4'hC, 8'h01};
        vecs[1] = '{32'h03A5, 16, 1, 0, 4'h3, 8'hA5};
        vecs[2] = '{32'h08FF, 16, 1, 0, 4'h8, 8'hFF};
        vecs[3] = '{32'hF90F, 16, 1, 0, 4'h9, 8'h0F};
        vecs[4] = '{32'h0A1F, 16, 1, 0, 4'hA, 8'h1F};
        vecs[5] = '{32'h0B07, 16, 1, 0, 4'hB, 8'h07};
        vecs[6] = '{32'h0F01, 16, 1, 0, 4'hF, 8'h01};
        vecs[7] = '{32'h0D55, 16, 1, 0, 4'hD, 8'h55};
        vecs[8] = '{32'h0000, 16, 1, 0, 4'h0, 8'h00};
        vecs[9] = '{32'h0123, 15, 0, 1, 4'h0, 8'h00};

        rst = 1'b1; sclk = 1'b0; din = 1'b0; load = 1'b1; dout_word = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        v0 = nv; e0 = ne;
        repeat (20) @(negedge clk);
        check("rst_valid_pulses", 64'(nv - v0), 64'd0);
        check("rst_err_pulses",   64'(ne - e0), 64'd0);
        check("rst_digits",   digits, 64'h0);
        check("rst_decode",   64'(decm), 64'h0);
        check("rst_intensity",64'(inten), 64'h0);
        check("rst_scan",     64'(scan), 64'h0);
        check("rst_shutdown_n", 64'(shdn), 64'h0);
        check("rst_dtest",    64'(dtest), 64'h0);
        check("rst_addr",     64'(waddr), 64'h0);
        check("rst_data",     64'(wdata), 64'h0);
        check("rst_dout",     64'(dout), 64'h0);

        for (int i = 0; i < 10; i++) begin
            v0 = nv; e0 = ne; v0n = nv_ns; e0n = ne_ns;
            frame_start();
            shift_bits(vecs[i].frame, vecs[i].nbits, 0, vecs[i].nbits);
            frame_end(lat);
            check($sformatf("v%0d_valid", i), 64'(nv - v0), 64'(vecs[i].exp_valid));
            check($sformatf("v%0d_err", i),   64'(ne - e0), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_ns_valid", i), 64'(nv_ns - v0n), 64'(vecs[i].exp_valid));
            check($sformatf("v%0d_ns_err", i),   64'(ne_ns - e0n), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_addr", i), 64'(waddr), 64'(vecs[i].exp_addr));
            check($sformatf("v%0d_data", i), 64'(wdata), 64'(vecs[i].exp_data));
            if (vecs[i].exp_valid == 1)
                check($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
            if (i == 0)
                check("v0_shutdown_n", 64'(shdn), 64'h1);
        end

        check("tbl_digits",    digits, 64'hFF00_0000_00A5_0000);
        check("tbl_decode",    64'(decm), 64'h0F);
        check("tbl_intensity", 64'(inten), 64'hF);
        check("tbl_scan",      64'(scan), 64'h7);
        check("tbl_shutdown_n",64'(shdn), 64'h1);
        check("tbl_dtest",     64'(dtest), 64'h1);

        // 32-bit cascade frame: relaxed instance takes the last 16 bits
        v0 = nv; e0 = ne; v0n = nv_ns; e0n = ne_ns;
        frame_start();
        shift_bits(32'h0111_0255, 32, 0, 32);
        frame_end(lat);
        check("c32_ns_valid", 64'(nv_ns - v0n), 64'd1);
        check("c32_ns_err",   64'(ne_ns - e0n), 64'd0);
        check("c32_ns_digit1", 64'(digits_ns[15:8]), 64'h55);
        check("c32_ns_addr",  64'(waddr_ns), 64'h2);
        check("c32_dout_word", 64'(dout_word), 64'h0111);
        check("c32_strict_err",   64'(ne - e0), 64'd1);
        check("c32_strict_valid", 64'(nv - v0), 64'd0);
        check("c32_strict_digit1", 64'(digits[15:8]), 64'h00);

        // Reset in the middle of a frame discards it
        v0 = nv; e0 = ne;
        frame_start();
        shift_bits(32'h0C01, 16, 0, 8);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_shutdown_n", 64'(shdn), 64'h0);
        check("mid_rst_digits", digits, 64'h0);
        check("mid_rst_intensity", 64'(inten), 64'h0);
        check("mid_rst_addr", 64'(waddr), 64'h0);
        rst = 1'b0;
        shift_bits(32'h0C01, 16, 8, 16);
        frame_end(lat);
        check("mid_rst_no_valid", 64'(nv - v0), 64'd0);
        check("mid_rst_no_err",   64'(ne - e0), 64'd0);
        check("mid_rst_still_shdn", 64'(shdn), 64'h0);

        v0 = nv;
        frame_start();
        shift_bits(32'h0C01, 16, 0, 16);
        frame_end(lat);
        check("post_rst_valid", 64'(nv - v0), 64'd1);
        check("post_rst_latency", 64'(lat), 64'd4);
        check("post_rst_shutdown_n", 64'(shdn), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
